// File: rtl/hanoi_pkg.sv
// hanoi_pkg: shared FSM/error encodings and width helper for the Towers of Hanoi engine.
`default_nettype none

package hanoi_pkg;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_AUTO   = 2'd1,
    ST_SOLVED = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_BAD_IND    = 3'd1,
    ERR_BAD_LOC    = 3'd2,
    ERR_SAME       = 3'd3,
    ERR_NOT_TOP    = 3'd4,
    ERR_ON_SMALLER = 3'd5
  } err_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hanoi_move_check.sv
// hanoi_move_check: combinational legality check of one ring move, shared by manual and solver paths.
`default_nettype none

module hanoi_move_check
  import hanoi_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 3,
  localparam int LW = clog2_min1(M),
  localparam int IW = clog2_min1(N)
) (
  input  logic [N*LW-1:0] rings,
  input  logic [IW-1:0]   ind,
  input  logic [LW-1:0]   loc,
  output logic            legal,
  output err_t            err_code
);

  logic [LW-1:0] cur;
  logic          not_top;
  logic          on_smaller;

  always_comb begin
    cur        = '0;
    not_top    = 1'b0;
    on_smaller = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(ind) == i) cur = rings[i*LW +: LW];
    end
    // Only rings smaller than the moving one can block it.
    for (int i = 0; i < N; i++) begin
      if (i < int'(ind)) begin
        if (rings[i*LW +: LW] == cur) not_top = 1'b1;
        if (rings[i*LW +: LW] == loc) on_smaller = 1'b1;
      end
    end
  end

  always_comb begin
    legal    = 1'b0;
    err_code = ERR_NONE;
    if (int'(ind) >= N)      err_code = ERR_BAD_IND;
    else if (int'(loc) >= M) err_code = ERR_BAD_LOC;
    else if (loc == cur)     err_code = ERR_SAME;
    else if (not_top)        err_code = ERR_NOT_TOP;
    else if (on_smaller)     err_code = ERR_ON_SMALLER;
    else                     legal    = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/hanoi_engine.sv
// hanoi_engine: Towers of Hanoi game state with manual moves and an optional iterative solver.
// Optional feature macro: HANOI_AUTO_SOLVE_EN (compiles in the AUTO state and move generator).
`default_nettype none

module hanoi_engine
  import hanoi_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 3,
  localparam int LW = clog2_min1(M),
  localparam int IW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            mv_valid,
  output logic            mv_ready,
  input  logic [IW-1:0]   mv_ind,
  input  logic [LW-1:0]   mv_loc,
  input  logic            auto_start,
  output logic [N*LW-1:0] rings,
  output logic            mv_ok,
  output logic            mv_err,
  output logic [2:0]      err_code,
  output logic [N-1:0]    move_count,
  output logic            solved,
  output logic            busy_auto
);

  localparam logic [N*LW-1:0] GOAL      = {N{LW'(M-1)}};
  localparam logic [N-1:0]    COUNT_MAX = '1;

  state_t          state;
  logic [IW-1:0]   chk_ind;
  logic [LW-1:0]   chk_loc;
  logic            chk_legal;
  err_t            chk_err;
  logic [N*LW-1:0] next_rings;

  assign mv_ready = (state == ST_PLAY);

`ifdef HANOI_AUTO_SOLVE_EN
  logic [N-1:0]  step;
  logic [IW-1:0] auto_k;
  logic [LW-1:0] cur_stick;
  logic [LW-1:0] auto_loc;
  logic [1:0]    cur_idx;
  logic [1:0]    dst_idx;

  // Ring to move is the trailing-zero count of the step; sticks 0,1,M-1 form the mod-3 ring.
  always_comb begin
    auto_k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (step[i]) auto_k = IW'(i);
    end
    cur_stick = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(auto_k) == i) cur_stick = rings[i*LW +: LW];
    end
    cur_idx = (cur_stick == '0) ? 2'd0 : (cur_stick == LW'(1)) ? 2'd1 : 2'd2;
    if (((N - int'(auto_k)) % 2) == 1) dst_idx = (cur_idx == 2'd0) ? 2'd2 : cur_idx - 2'd1;
    else                                dst_idx = (cur_idx == 2'd2) ? 2'd0 : cur_idx + 2'd1;
    auto_loc = (dst_idx == 2'd0) ? LW'(0) : (dst_idx == 2'd1) ? LW'(1) : LW'(M-1);
  end

  assign chk_ind = (state == ST_AUTO) ? auto_k   : mv_ind;
  assign chk_loc = (state == ST_AUTO) ? auto_loc : mv_loc;
`else
  logic unused_auto;
  assign unused_auto = auto_start;
  assign chk_ind     = mv_ind;
  assign chk_loc     = mv_loc;
  assign busy_auto   = 1'b0;
`endif

  hanoi_move_check #(.N(N), .M(M)) u_check (
    .rings    (rings),
    .ind      (chk_ind),
    .loc      (chk_loc),
    .legal    (chk_legal),
    .err_code (chk_err)
  );

  always_comb begin
    next_rings = rings;
    for (int i = 0; i < N; i++) begin
      if (int'(chk_ind) == i) next_rings[i*LW +: LW] = chk_loc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_PLAY;
      rings      <= '0;
      move_count <= '0;
      mv_ok      <= 1'b0;
      mv_err     <= 1'b0;
      err_code   <= ERR_NONE;
      solved     <= 1'b0;
`ifdef HANOI_AUTO_SOLVE_EN
      step       <= N'(1);
      busy_auto  <= 1'b0;
`endif
    end else if (clear) begin
      state      <= ST_PLAY;
      rings      <= '0;
      move_count <= '0;
      mv_ok      <= 1'b0;
      mv_err     <= 1'b0;
      err_code   <= ERR_NONE;
      solved     <= 1'b0;
`ifdef HANOI_AUTO_SOLVE_EN
      step       <= N'(1);
      busy_auto  <= 1'b0;
`endif
    end else begin
      mv_ok  <= 1'b0;
      mv_err <= 1'b0;
      case (state)
        ST_PLAY: begin
`ifdef HANOI_AUTO_SOLVE_EN
          if (auto_start && (rings == '0)) begin
            state     <= ST_AUTO;
            step      <= N'(1);
            busy_auto <= 1'b1;
          end else
`endif
          if (mv_valid) begin
            if (chk_legal) begin
              rings      <= next_rings;
              mv_ok      <= 1'b1;
              move_count <= (move_count == COUNT_MAX) ? move_count : move_count + 1'b1;
              if (next_rings == GOAL) begin
                state  <= ST_SOLVED;
                solved <= 1'b1;
              end
            end else begin
              mv_err   <= 1'b1;
              err_code <= chk_err;
            end
          end
        end
`ifdef HANOI_AUTO_SOLVE_EN
        ST_AUTO: begin
          if (chk_legal) begin
            rings      <= next_rings;
            mv_ok      <= 1'b1;
            move_count <= (move_count == COUNT_MAX) ? move_count : move_count + 1'b1;
            step       <= step + 1'b1;
            if (next_rings == GOAL) begin
              state     <= ST_SOLVED;
              solved    <= 1'b1;
              busy_auto <= 1'b0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hanoi_engine.sv
// tb_hanoi_engine: scoreboard bench for hanoi_engine with N=3, M=3.
`default_nettype none
`timescale 1ns/1ps

module tb_hanoi_engine;

  localparam int N = 3;
  localparam int M = 3;

  logic       clk = 1'b0;
  logic       rst, clear, mv_valid, auto_start;
  logic [1:0] mv_ind, mv_loc;
  logic       mv_ready, mv_ok, mv_err, solved, busy_auto;
  logic [5:0] rings;
  logic [2:0] err_code;
  logic [2:0] move_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       ok;
    logic [2:0] code;
    logic [5:0] rings;
    logic [2:0] count;
    logic       solved;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [1:0] sol_ind [7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
  logic [1:0] sol_loc [7] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd2};
  logic [5:0] sol_r   [7] = '{6'b000010, 6'b000110, 6'b000101, 6'b100101,
                              6'b100100, 6'b101000, 6'b101010};

  hanoi_engine #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .mv_valid   (mv_valid),
    .mv_ready   (mv_ready),
    .mv_ind     (mv_ind),
    .mv_loc     (mv_loc),
    .auto_start (auto_start),
    .rings      (rings),
    .mv_ok      (mv_ok),
    .mv_err     (mv_err),
    .err_code   (err_code),
    .move_count (move_count),
    .solved     (solved),
    .busy_auto  (busy_auto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic expect_ev(input logic ok, input logic [2:0] code, input logic [5:0] r,
                           input logic [2:0] cnt, input logic s);
    exp_t e;
    e.ok = ok; e.code = code; e.rings = r; e.count = cnt; e.solved = s;
    sb.push_back(e);
  endtask

  task automatic do_move(input logic [1:0] ind, input logic [1:0] loc);
    @(posedge clk); #1;
    mv_valid = 1'b1; mv_ind = ind; mv_loc = loc;
    @(posedge clk); #1;
    mv_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic pulse_auto();
    @(posedge clk); #1 auto_start = 1'b1;
    @(posedge clk); #1 auto_start = 1'b0;
  endtask

  // Monitor: every mv_ok / mv_err pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (mv_ok || mv_err) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse ok=%0d err=%0d code=%0d rings=%b count=%0d",
                   mv_ok, mv_err, err_code, rings, move_count);
        end else begin
          mon_e = sb.pop_front();
          if (mv_ok !== mon_e.ok || mv_err !== !mon_e.ok ||
              (!mon_e.ok && err_code !== mon_e.code) || rings !== mon_e.rings ||
              move_count !== mon_e.count || solved !== mon_e.solved) begin
            failures++;
            $display("FAIL move_event actual ok=%0d err=%0d code=%0d rings=%b count=%0d solved=%0d required ok=%0d code=%0d rings=%b count=%0d solved=%0d",
                     mv_ok, mv_err, err_code, rings, move_count, solved,
                     mon_e.ok, mon_e.code, mon_e.rings, mon_e.count, mon_e.solved);
          end
        end
      end
    end
  end

`ifdef HANOI_AUTO_SOLVE_EN
  task automatic auto_run_full(input logic with_manual);
    for (int i = 0; i < 7; i++) expect_ev(1'b1, 3'd0, sol_r[i], 3'(i + 1), (i == 6));
    pulse_auto();
    chk("auto_busy", 32'(busy_auto), 32'd1);
    chk("auto_ready_low", 32'(mv_ready), 32'd0);
    if (with_manual) begin
      mv_valid = 1'b1; mv_ind = 2'd2; mv_loc = 2'd1;
    end
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("auto_ok_cycle%0d", i), 32'(mv_ok), 32'd1);
    end
    mv_valid = 1'b0;
    chk("auto_rings", 32'(rings), 32'b101010);
    chk("auto_solved", 32'(solved), 32'd1);
    chk("auto_count", 32'(move_count), 32'd7);
    chk("auto_busy_done", 32'(busy_auto), 32'd0);
  endtask
`endif

  initial begin
    rst = 1'b1; clear = 1'b0; mv_valid = 1'b0; auto_start = 1'b0;
    mv_ind = '0; mv_loc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rings", 32'(rings), 32'd0);
    chk("reset_count", 32'(move_count), 32'd0);
    chk("reset_ready", 32'(mv_ready), 32'd1);
    chk("reset_flags", {28'd0, solved, busy_auto, mv_ok, mv_err}, 32'd0);
    chk("reset_err_code", 32'(err_code), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Manual moves and each rejection reason.
    expect_ev(1'b1, 3'd0, 6'b000010, 3'd1, 1'b0); do_move(2'd0, 2'd2);
    expect_ev(1'b0, 3'd5, 6'b000010, 3'd1, 1'b0); do_move(2'd1, 2'd2);
    expect_ev(1'b0, 3'd4, 6'b000010, 3'd1, 1'b0); do_move(2'd2, 2'd1);
    expect_ev(1'b0, 3'd2, 6'b000010, 3'd1, 1'b0); do_move(2'd1, 2'd3);
    expect_ev(1'b0, 3'd1, 6'b000010, 3'd1, 1'b0); do_move(2'd3, 2'd0);
    expect_ev(1'b0, 3'd3, 6'b000010, 3'd1, 1'b0); do_move(2'd0, 2'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("err_code_held", 32'(err_code), 32'd3);

    do_clear();
    @(negedge clk);
    chk("clear_rings", 32'(rings), 32'd0);
    chk("clear_count", 32'(move_count), 32'd0);
    chk("clear_err_code", 32'(err_code), 32'd0);
    expect_ev(1'b0, 3'd4, 6'b000000, 3'd0, 1'b0); do_move(2'd2, 2'd1);

`ifdef HANOI_AUTO_SOLVE_EN
    auto_run_full(1'b1);
    do_clear();
    // Reset mid-solve: only three moves may ever be reported.
    for (int i = 0; i < 3; i++) expect_ev(1'b1, 3'd0, sol_r[i], 3'(i + 1), 1'b0);
    pulse_auto();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_rings", 32'(rings), 32'd0);
    chk("rst_mid_ready", 32'(mv_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy_auto), 32'd0);
    chk("rst_mid_count", 32'(move_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_settled", 32'(rings), 32'd0);
    auto_run_full(1'b0);
    do_clear();
`else
    pulse_auto();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("noauto_busy", 32'(busy_auto), 32'd0);
    chk("noauto_rings", 32'(rings), 32'd0);
    chk("noauto_ready", 32'(mv_ready), 32'd1);
`endif

    // Manual optimal solution.
    do_clear();
    for (int i = 0; i < 7; i++) begin
      expect_ev(1'b1, 3'd0, sol_r[i], 3'(i + 1), (i == 6));
      do_move(sol_ind[i], sol_loc[i]);
    end
    @(negedge clk);
    chk("manual_solved", 32'(solved), 32'd1);
    chk("manual_ready_low", 32'(mv_ready), 32'd0);
    chk("manual_busy", 32'(busy_auto), 32'd0);
    do_move(2'd0, 2'd0);
    pulse_auto();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("solved_hold_rings", 32'(rings), 32'b101010);
    chk("solved_hold_count", 32'(move_count), 32'd7);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
